bit_serial_adder: RTL

Multi-cycle, LSB-first serial adder. It sits directly on top of the single-bit full-adder stage and drives that stage one bit per clock, holding the carry in a flop between bits. It accepts two WIDTH-bit operands plus a carry-in on a start pulse. After WIDTH cycles of bit processing it presents a registered WIDTH-bit sum and carry-out with a one-cycle done pulse. This is the area-minimal adder option next to the ripple-carry variants in the adder family.

---
 rtl/bit_serial_adder_pkg.sv | 15 +
 rtl/bit_serial_adder_if.sv | 23 ++
 rtl/bit_serial_adder_full_adder_1bit.sv | 16 +
 rtl/bit_serial_adder.sv | 101 ++++++++++
 4 files changed

// File: rtl/bit_serial_adder_pkg.sv
// Shared definitions for the adder family: FSM state encoding and counter sizing.
package bit_serial_adder_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } state_t;

   // Bit-counter width for a given operand width; never narrower than one bit.
   function automatic int unsigned cnt_w(input int unsigned width);
      return (width <= 1) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/bit_serial_adder_if.sv
// Request/result bundle for the serial adder.
interface bit_serial_adder_if #(
   parameter int unsigned WIDTH = 8
);
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );
endinterface

// File: rtl/bit_serial_adder_full_adder_1bit.sv
// Single-bit full-adder stage, purely combinational.
module full_adder_1bit (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   // Sum and majority carry of the three input bits.
   always_comb begin
      sum  = a ^ b ^ cin;
      cout = (a & b) | (a & cin) | (b & cin);
   end

endmodule

// File: rtl/bit_serial_adder.sv
// LSB-first serial adder: one full-adder stage reused over WIDTH clocks, carry held in a flop.
module bit_serial_adder
   import bit_serial_adder_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input logic               clk,
   input logic               rst_n,
   bit_serial_adder_if.slave bus
);

   localparam int unsigned        CNT_W    = cnt_w(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] psum_q;
   logic [WIDTH-1:0] psum_shift;
   logic             carry_q;
   logic [CNT_W-1:0] cnt_q;
   logic             busy_q;
   logic             done_q;
   logic [WIDTH-1:0] sum_q;
   logic             cout_q;
   logic             fa_sum;
   logic             fa_cout;

   full_adder_1bit u_fa (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .cin  (carry_q),
      .sum  (fa_sum),
      .cout (fa_cout)
   );

   // Partial sum shifted right with this cycle's bit entering at the MSB (also valid for WIDTH=1).
   always_comb begin
      psum_shift            = psum_q >> 1;
      psum_shift[WIDTH-1] = fa_sum;
   end

   // Serial control FSM with datapath registers and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.start) begin
                  a_q     <= bus.a;
                  b_q     <= bus.b;
                  carry_q <= bus.cin;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= StRun;
               end
            end
            StRun: begin
               a_q     <= a_q >> 1;
               b_q     <= b_q >> 1;
               psum_q  <= psum_shift;
               carry_q <= fa_cout;
               cnt_q   <= cnt_q + CNT_W'(1);
               if (cnt_q == LAST_CNT) begin
                  // Last bit: publish the full sum including this cycle's bit.
                  sum_q   <= psum_shift;
                  cout_q  <= fa_cout;
                  done_q  <= 1'b1;
                  state_q <= StDone;
               end
            end
            StDone: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

endmodule
